// File: rtl/turn_ctrl.sv
// -----------------------------------------------------------------------------
// turn_ctrl
//
// Turn sequencer for the 2-4 player board game. It sits directly upstream of
// the per-player position counters. A flipped card is compared against the
// picture on the tile ahead of the current player:
//   - match : pulse the step strobe D. If the player lands on a tile that
//             another active player occupies, pulse D again to hop over it.
//             Hops are capped at N-1. A match keeps the turn.
//   - miss  : pulse miss and pass the turn to the next player.
//
// Optional feature (macro TURN_TIMEOUT_EN):
//   When the macro is defined, a WAIT_CARD cycle counter forces a pass after
//   TIMEOUT_CYC cycles without a card. When it is undefined, WAIT_CARD waits
//   indefinitely and the TIMEOUT_CYC parameter does not exist.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   M              in   3  mode: 3'b010 setup, 3'b011 play, anything else hold
//   N              in   3  player count 2..4 (any other value counts as 2)
//   card_valid     in   1  single-cycle qualifier for card_id
//   card_id        in   4  picture on the flipped card
//   p1_cnt..p4_cnt in   5  current positions from the position counters
//   D              out  1  single-cycle step strobe to every position counter
//   p_da1..p_da4   out  1  one-hot enable for the current player's counter
//   turn           out  2  current player index 0..N-1
//   miss           out  1  single-cycle pulse when a card misses
//   busy           out  1  high in every state except IDLE and WAIT_CARD
// -----------------------------------------------------------------------------
module turn_ctrl #(
  parameter int NUM_TILES   = 24,
  parameter int NUM_PICS    = 12
`ifdef TURN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 2**24
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] M,
  input  logic [2:0] N,
  input  logic       card_valid,
  input  logic [3:0] card_id,
  input  logic [4:0] p1_cnt,
  input  logic [4:0] p2_cnt,
  input  logic [4:0] p3_cnt,
  input  logic [4:0] p4_cnt,
  output logic       D,
  output logic       p_da1,
  output logic       p_da2,
  output logic       p_da3,
  output logic       p_da4,
  output logic [1:0] turn,
  output logic       miss,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CARD,
    CHECK,
    STEP,
    SETTLE,
    PASS
  } state_t;

  localparam logic [2:0] M_SETUP   = 3'b010;
  localparam logic [2:0] M_PLAY    = 3'b011;
  localparam logic [4:0] LAST_TILE = 5'(NUM_TILES - 1);
  localparam logic [4:0] PICS      = 5'(NUM_PICS);

  // Picture index of a tile. Repeated compare-and-subtract replaces a
  // divider: tiles never exceed NUM_TILES-1, so NUM_TILES/NUM_PICS rounds
  // of subtraction are always enough.
  function automatic logic [4:0] pic_of(input logic [4:0] tile);
    logic [4:0] v;
    v = tile;
    for (int i = 0; i < NUM_TILES / NUM_PICS; i++) begin
      if (v >= PICS) v = v - PICS;
    end
    return v;
  endfunction

  state_t     state, state_nxt;
  logic [1:0] turn_nxt;
  logic [3:0] card_q, card_nxt;
  logic [1:0] hops_q, hops_nxt;

  logic       mode_setup;
  logic       mode_play;
  logic [1:0] last_turn;   // index of the last active player (N_eff - 1)
  logic [4:0] pos [4];
  logic [4:0] pos_cur;
  logic [4:0] ahead;
  logic       match;
  logic       collide;
  logic       timeout;
  logic [3:0] pda_vec;

  assign mode_setup = (M == M_SETUP);
  assign mode_play  = (M == M_PLAY);

  always_comb begin
    case (N)
      3'd3:    last_turn = 2'd2;
      3'd4:    last_turn = 2'd3;
      default: last_turn = 2'd1;
    endcase
  end

  assign pos[0]  = p1_cnt;
  assign pos[1]  = p2_cnt;
  assign pos[2]  = p3_cnt;
  assign pos[3]  = p4_cnt;
  assign pos_cur = pos[turn];

  assign ahead = (pos_cur == LAST_TILE) ? 5'd0 : pos_cur + 5'd1;
  assign match = ({1'b0, card_q} < PICS) && ({1'b0, card_q} == pic_of(ahead));

  // In SETTLE the counter has already moved, so pos_cur is the landing tile.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != turn && 2'(i) <= last_turn && pos[i] == pos_cur)
        collide = 1'b1;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] wait_cnt;

  assign timeout = (wait_cnt == TW'(TIMEOUT_CYC - 1));

  // Cleared whenever we are outside WAIT_CARD, so every entry starts at 0.
  // A hold mode freezes the count along with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state != WAIT_CARD) wait_cnt <= '0;
    else if (mode_play && !timeout)
      wait_cnt <= wait_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every register is updated with non-blocking assignments so all
  // flops sample the pre-edge values of each other, independent of
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      turn   <= '0;
      card_q <= '0;
      hops_q <= '0;
    end else begin
      state  <= state_nxt;
      turn   <= turn_nxt;
      card_q <= card_nxt;
      hops_q <= hops_nxt;
    end
  end

  // NOTE: each output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    turn_nxt  = turn;
    card_nxt  = card_q;
    hops_nxt  = hops_q;

    if (mode_setup) begin
      state_nxt = IDLE;
      turn_nxt  = '0;
      hops_nxt  = '0;
    end else if (mode_play) begin
      case (state)
        IDLE:      state_nxt = WAIT_CARD;
        WAIT_CARD: begin
          if (card_valid) begin
            card_nxt  = card_id;
            state_nxt = CHECK;
          end else if (timeout) begin
            state_nxt = PASS;
          end
        end
        CHECK: begin
          hops_nxt  = '0;
          state_nxt = match ? STEP : PASS;
        end
        STEP:      state_nxt = SETTLE;
        SETTLE: begin
          if (collide && hops_q < last_turn) begin
            hops_nxt  = hops_q + 2'd1;
            state_nxt = STEP;
          end else begin
            state_nxt = WAIT_CARD;
          end
        end
        PASS: begin
          turn_nxt  = (turn >= last_turn) ? 2'd0 : turn + 2'd1;
          state_nxt = WAIT_CARD;
        end
        default:   state_nxt = IDLE;
      endcase
    end

    // Player count shrank below the current player: restart from player 0.
    if (turn > last_turn) turn_nxt = '0;
  end

  // Strobes are qualified by play mode: a setup request drops a strobe in
  // flight and a hold mode silences them while the state is frozen.
  assign D       = mode_play && (state == STEP);
  assign miss    = mode_play && (state == PASS);
  assign busy    = (state != IDLE) && (state != WAIT_CARD);
  assign pda_vec = (state == IDLE) ? 4'b0000 : (4'b0001 << turn);

  assign {p_da4, p_da3, p_da2, p_da1} = pda_vec;

endmodule
